// File: rtl/if_id_queue_if.sv
// Fetch-packet type shared by fetch, the IF/ID queue and decode, plus the
// interface bundling the queue's fetch/decode-side signals.
package if_id_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid_if_id;
  } if_id_reg_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

interface if_id_queue_if #(
  parameter int DEPTH = 4
);
  import if_id_pkg::*;

  if_id_reg_t                   if_in;
  logic                         flush;
  logic                         id_stall;
  if_id_reg_t                   id_out;
  logic                         fetch_stall;
  logic [$clog2(DEPTH):0]       count;

  // master: the pipeline side driving fetch packets and control
  modport master (
    output if_in, flush, id_stall,
    input  id_out, fetch_stall, count
  );

  // slave: the queue itself
  modport slave (
    input  if_in, flush, id_stall,
    output id_out, fetch_stall, count
  );

endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of fetch packets with registered
// back-pressure to fetch and single-cycle flush on branch redirect.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_id_queue_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_id_reg_t     mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           enq, deq;
  logic           full;

  // Full is taken from registered count only, so id_stall never reaches pc_stall.
  assign full          = (count_q == CW'(DEPTH));
  assign q.fetch_stall = full;
  assign q.count       = count_q;

  assign enq = q.if_in.valid_if_id && !full && !q.flush;
  assign deq = (count_q != '0) && !q.id_stall && !q.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // count/rd_ptr, which are reset, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= q.if_in;
  end

  // NOTE: every field gets a default before the conditional override, so no
  // latch is inferred for the output packet.
  always_comb begin
    q.id_out.pc          = '0;
    q.id_out.instruction = NOP_INSN;
    q.id_out.pc_plus4    = '0;
    q.id_out.valid_if_id = 1'b0;
    if ((count_q != '0) && !q.flush) begin
      q.id_out             = mem_q[rd_ptr_q];
      q.id_out.valid_if_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed stimulus with an expected-pc scoreboard
// drained by an independent negedge monitor.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  if_id_queue_if #(.DEPTH(DEPTH)) q ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_count = 0;
  bit          checking = 1'b0;
  bit          pend_enq, pend_deq;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  // Drive one cycle's inputs and record what the queue must do with them.
  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic st);
    q.if_in.pc          = pc;
    q.if_in.instruction = insn_of(pc);
    q.if_in.pc_plus4    = pc + 32'd4;
    q.if_in.valid_if_id = v;
    q.flush             = fl;
    q.id_stall          = st;
    pend_enq = reset && v && (model_count != DEPTH) && !fl;
    pend_deq = reset && (model_count != 0) && !st && !fl;
    if (pend_enq) exp_q.push_back(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset || q.flush) begin
      model_count = 0;
      exp_q.delete();
    end else begin
      model_count = model_count + int'(pend_enq) - int'(pend_deq);
    end
    if (!reset) checking = 1'b1;
  endtask

  task automatic cycle(input logic v, input logic [31:0] pc, input logic fl, input logic st);
    drive(v, pc, fl, st);
    step();
  endtask

  // Monitor: compares the presented head against the scoreboard each cycle.
  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 32'(q.id_out.valid_if_id), 32'((model_count != 0) && !q.flush));
      check("count", 32'(q.count), model_count);
      check("fetch_stall", 32'(q.fetch_stall), 32'(model_count == DEPTH));
      if (q.id_out.valid_if_id) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", q.id_out.pc, 32'hFFFF_FFFF);
        end else begin
          check("out_pc", q.id_out.pc, exp_q[0]);
          check("out_insn", q.id_out.instruction, insn_of(exp_q[0]));
          check("out_pc4", q.id_out.pc_plus4, exp_q[0] + 32'd4);
          if (!q.id_stall && !q.flush && reset) void'(exp_q.pop_front());
        end
      end else begin
        check("bubble_insn", q.id_out.instruction, 32'h0000_0013);
        check("bubble_pc", q.id_out.pc, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int cyc;
    bit acc;

    // 1. Reset held 3 cycles with a valid packet on the input
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    check("rst_count", 32'(q.count), 32'd0);
    check("rst_fetch_stall", 32'(q.fetch_stall), 32'd0);
    check("rst_valid", 32'(q.id_out.valid_if_id), 32'd0);
    check("rst_insn", q.id_out.instruction, 32'h0000_0013);
    reset = 1'b1;

    // 2. Streaming: occupancy stays at one, head follows one cycle later
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
      check("stream_count", 32'(q.count), 32'd1);
      check("stream_pc", q.id_out.pc, 32'(i * 4));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("stream_empty", 32'(q.count), 32'd0);

    // 3. Fill while decode is stalled, then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b1);
    check("fill_count", 32'(q.count), 32'd4);
    check("fill_fetch_stall", 32'(q.fetch_stall), 32'd1);
    check("fill_head", q.id_out.pc, 32'h00);
    cycle(1'b1, 32'h10, 1'b0, 1'b1);
    check("full_hold_count", 32'(q.count), 32'd4);
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    check("first_deq_count", 32'(q.count), 32'd3);
    check("first_deq_fetch_stall", 32'(q.fetch_stall), 32'd0);
    check("first_deq_head", q.id_out.pc, 32'h04);
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    check("resume_count", 32'(q.count), 32'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_empty", 32'(q.count), 32'd0);

    // 4. Ten packets with id_stall toggling every 3 cycles, across a wrap
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 100) begin
      drive(1'b1, 32'h40 + 32'(idx * 4), 1'b0, 1'(((cyc / 3) % 2) == 1));
      acc = pend_enq;
      step();
      if (acc) idx++;
      cyc++;
    end
    check("wrap_all_issued", 32'(idx), 32'd10);
    cyc = 0;
    while (model_count != 0 && cyc < 20) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cyc++;
    end
    check("wrap_drained", 32'(q.count), 32'd0);
    check("wrap_all_seen", 32'(exp_q.size()), 32'd0);

    // 5. Flush with three wrong-path packets queued
    cycle(1'b1, 32'h20, 1'b0, 1'b1);
    cycle(1'b1, 32'h24, 1'b0, 1'b1);
    cycle(1'b1, 32'h28, 1'b0, 1'b1);
    check("pre_flush_count", 32'(q.count), 32'd3);
    drive(1'b1, 32'h2C, 1'b1, 1'b0);
    #2;
    check("flush_valid", 32'(q.id_out.valid_if_id), 32'd0);
    step();
    check("post_flush_count", 32'(q.count), 32'd0);
    cycle(1'b1, 32'h80, 1'b0, 1'b0);
    check("redirect_pc", q.id_out.pc, 32'h80);
    check("redirect_count", 32'(q.count), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("redirect_alone", 32'(q.id_out.valid_if_id), 32'd0);

    // 6. Reset while full and stalled
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b1);
    check("pre_rst_count", 32'(q.count), 32'd4);
    reset = 1'b0;
    cycle(1'b1, 32'h300, 1'b0, 1'b1);
    check("midrst_count", 32'(q.count), 32'd0);
    check("midrst_fetch_stall", 32'(q.fetch_stall), 32'd0);
    check("midrst_valid", 32'(q.id_out.valid_if_id), 32'd0);
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
